// File: rtl/argmax_classifier.sv
// Final MNIST classification stage: latches the layer-2 scores and scans them
// one per cycle for the winning class, its score and the best-minus-runner-up margin.
module argmax_classifier #(
  parameter int DATA_WIDTH  = 8,
  parameter int CLASS_COUNT = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [CLASS_COUNT*DATA_WIDTH-1:0] scores,
  output logic                              busy,
  output logic                              result_valid,
  input  logic                              result_ack,
  output logic [IDX_WIDTH-1:0]              class_idx,
  output logic [DATA_WIDTH-1:0]             class_score,
  output logic [DATA_WIDTH-1:0]             margin
);

  // state  | meaning
  // IDLE   | waiting for start, last result held on outputs
  // SCAN   | comparing latched score[k] against running best/second
  // RESULT | result_valid high, waiting for result_ack
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_K = IDX_WIDTH'(CLASS_COUNT - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] score_mem [CLASS_COUNT];
  logic [IDX_WIDTH-1:0]  k;
  logic [IDX_WIDTH-1:0]  best_idx;
  logic [DATA_WIDTH-1:0] best;
  logic [DATA_WIDTH-1:0] second;

  logic [DATA_WIDTH-1:0] s;
  logic [DATA_WIDTH-1:0] best_nxt;
  logic [DATA_WIDTH-1:0] second_nxt;
  logic [IDX_WIDTH-1:0]  idx_nxt;

  // Strict greater-than keeps the lowest index on ties; the tied value still
  // lands in second so the margin reads zero.
  always_comb begin
    s          = score_mem[k];
    best_nxt   = best;
    second_nxt = second;
    idx_nxt    = best_idx;
    if (s > best) begin
      second_nxt = best;
      best_nxt   = s;
      idx_nxt    = k;
    end else if (s > second) begin
      second_nxt = s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      k            <= '0;
      best_idx     <= '0;
      best         <= '0;
      second       <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      class_idx    <= '0;
      class_score  <= '0;
      margin       <= '0;
      for (int i = 0; i < CLASS_COUNT; i++) score_mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < CLASS_COUNT; i++)
              score_mem[i] <= scores[i*DATA_WIDTH +: DATA_WIDTH];
            best     <= scores[DATA_WIDTH-1:0];
            best_idx <= '0;
            second   <= '0;
            k        <= IDX_WIDTH'(1);
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          best     <= best_nxt;
          second   <= second_nxt;
          best_idx <= idx_nxt;
          if (k == LAST_K) begin
            // k parks at 0 so the score read never leaves the table
            k            <= '0;
            class_idx    <= idx_nxt;
            class_score  <= best_nxt;
            margin       <= best_nxt - second_nxt;
            result_valid <= 1'b1;
            state        <= RESULT;
          end else begin
            k <= k + 1'b1;
          end
        end
        RESULT: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: directed plan cases plus random
// score sets, compared against a plain max/runner-up reference model.
module tb_argmax_classifier;
  localparam int DW = 8;
  localparam int CC = 10;
  localparam int IW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             result_ack;
  logic [CC*DW-1:0] scores;
  logic             busy;
  logic             result_valid;
  logic [IW-1:0]    class_idx;
  logic [DW-1:0]    class_score;
  logic [DW-1:0]    margin;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] cur [CC];
  int exp_idx, exp_best, exp_margin;

  argmax_classifier #(.DATA_WIDTH(DW), .CLASS_COUNT(CC), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .scores(scores), .busy(busy),
    .result_valid(result_valid), .result_ack(result_ack), .class_idx(class_idx),
    .class_score(class_score), .margin(margin)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: first index holding the maximum; runner-up is the largest
  // value among all other positions (equals max on a tie).
  task automatic compute_model;
    int sec;
    exp_best = -1;
    exp_idx  = 0;
    for (int i = 0; i < CC; i++)
      if (int'(cur[i]) > exp_best) begin exp_best = int'(cur[i]); exp_idx = i; end
    sec = 0;
    for (int i = 0; i < CC; i++)
      if (i != exp_idx && int'(cur[i]) > sec) sec = int'(cur[i]);
    exp_margin = exp_best - sec;
  endtask

  task automatic apply_scores;
    for (int i = 0; i < CC; i++) scores[i*DW +: DW] = cur[i];
  endtask

  task automatic start_run;
    apply_scores();
    compute_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    check("valid_after_start", 32'(result_valid), 0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 32'(result_valid), 1);
    check({tag, "_idx"},   32'(class_idx),    exp_idx);
    check({tag, "_score"}, 32'(class_score),  exp_best);
    check({tag, "_margin"},32'(margin),       exp_margin);
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int n = 0;
    while (!result_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check_outputs(tag);
  endtask

  task automatic finish_run(input string tag, input int hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_outputs({tag, "_hold"});
      check({tag, "_hold_busy"}, 32'(busy), 1);
    end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check({tag, "_valid_after_ack"}, 32'(result_valid), 0);
    check({tag, "_busy_after_ack"},  32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; result_ack = 1'b0; scores = '0;
    for (int i = 0; i < CC; i++) cur[i] = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy",   32'(busy), 0);
    check("rst_valid",  32'(result_valid), 0);
    check("rst_idx",    32'(class_idx), 0);
    check("rst_score",  32'(class_score), 0);
    check("rst_margin", 32'(margin), 0);

    // distinct scores, ack after 3 cycles
    cur = '{8'd10, 8'd20, 8'd30, 8'd250, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    start_run();
    wait_result("distinct", CC - 1);
    check("distinct_idx_const", 32'(class_idx), 3);
    check("distinct_margin_const", 32'(margin), 160);
    finish_run("distinct", 3);

    // tie between classes 2 and 7
    for (int i = 0; i < CC; i++) cur[i] = 8'd0;
    cur[2] = 8'd200; cur[7] = 8'd200;
    start_run();
    wait_result("tie", CC - 1);
    check("tie_idx_const", 32'(class_idx), 2);
    check("tie_margin_const", 32'(margin), 0);
    finish_run("tie", 0);

    // all zero
    for (int i = 0; i < CC; i++) cur[i] = 8'd0;
    start_run();
    wait_result("zero", CC - 1);
    finish_run("zero", 1);

    // max at last class
    cur[CC-1] = 8'd255;
    start_run();
    wait_result("last", CC - 1);
    check("last_idx_const", 32'(class_idx), 9);
    check("last_margin_const", 32'(margin), 255);
    finish_run("last", 0);

    // scores and start disturbed during SCAN and RESULT
    cur = '{8'd5, 8'd100, 8'd7, 8'd33, 8'd99, 8'd1, 8'd2, 8'd3, 8'd4, 8'd6};
    start_run();
    tick(); tick();
    scores = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("scan_start_busy", 32'(busy), 1);
    wait_result("ignore", CC - 4);
    scores = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("result_start_busy", 32'(busy), 1);
    check_outputs("ignore_result");
    finish_run("ignore", 1);
    tick();
    check("no_queued_start_busy", 32'(busy), 0);
    check("no_queued_start_valid", 32'(result_valid), 0);

    // reset on the 5th SCAN cycle
    cur = '{8'd9, 8'd8, 8'd77, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    start_run();
    repeat (4) tick();
    rst = 1'b1;
    start = 1'b1;
    result_ack = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; result_ack = 1'b0;
    check("midrst_busy",   32'(busy), 0);
    check("midrst_valid",  32'(result_valid), 0);
    check("midrst_idx",    32'(class_idx), 0);
    check("midrst_score",  32'(class_score), 0);
    check("midrst_margin", 32'(margin), 0);
    tick();
    check("midrst_idle_busy", 32'(busy), 0);
    start_run();
    wait_result("after_rst", CC - 1);
    finish_run("after_rst", 0);

    // back-to-back with ack held high
    cur = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    result_ack = 1'b1;
    start_run();
    wait_result("b2b_a", CC - 1);
    tick();
    check("b2b_a_valid_drop", 32'(result_valid), 0);
    check("b2b_a_busy_drop",  32'(busy), 0);
    cur = '{8'd40, 8'd200, 8'd199, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    start_run();
    wait_result("b2b_b", CC - 1);
    tick();
    check("b2b_b_valid_drop", 32'(result_valid), 0);
    result_ack = 1'b0;

    // random score sets, narrow ranges every other run to force ties
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < CC; i++)
        cur[i] = (r % 2 == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom_range(0, 3));
      start_run();
      wait_result("rand", CC - 1);
      finish_run("rand", $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/argmax_classifier.md
# argmax_classifier

Final classification stage of the MNIST inference engine, directly downstream of the layer-2 sigmoid controller. When the controller signals `done`, the 10 layer-2 sigmoid outputs sit in the LUT-save shift register. This block latches them as a parallel bus on `start` and scans them one per cycle to find the winning digit and its score. It also reports a confidence margin (best minus runner-up) and holds the result under a valid/ack handshake until the host consumes it.

## Interface
- `DATA_WIDTH`, 8, width of one unsigned sigmoid score
- `CLASS_COUNT`, 10, number of output classes (≥2)
- `IDX_WIDTH`, 4, width of class index (≥ clog2(CLASS_COUNT))

- `clk`  in  1  clock, rising-edge
- `rst`  in  1  reset rst, synchronous, active-high
- `start`  in  1  request classification; sampled only in IDLE
- `scores`  in  CLASS_COUNT*DATA_WIDTH  unsigned scores; class k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- `busy`  out  1  high whenever state ≠ IDLE
- `result_valid`  out  1  result outputs valid; high only in RESULT
- `result_ack`  in  1  host consumes result; meaningful only while result_valid=1
- `class_idx`  out  IDX_WIDTH  index of the maximum score
- `class_score`  out  DATA_WIDTH  maximum score
- `margin`  out  DATA_WIDTH  class_score minus second-highest score, unsigned

## Operation
- States: IDLE, SCAN, RESULT.
- IDLE, start=1:
  - Latch `scores` into an internal register; later changes on `scores` are ignored until the next start.
  - Initialise best=score[0], best_idx=0, second=0, k=1.
  - Go to SCAN.
- IDLE, start=0: stay.
- SCAN: each cycle compare s=latched score[k], unsigned.
  - s > best: second←best, best←s, best_idx←k.
  - else s > second: second←s.
  - else: no change.
  - k←k+1. After processing k=CLASS_COUNT-1, go to RESULT.
- Tie rule: strict greater-than, so the lowest index wins among equal maxima. A tied value still updates second, giving margin 0.
- RESULT:
  - Drive class_idx=best_idx, class_score=best, margin=best−second. No underflow is possible because second ≤ best by construction.
  - Hold all result outputs stable while result_ack=0.
  - result_ack=1: go to IDLE.
- Result outputs are registered and keep their last values after returning to IDLE; result_valid is the only qualifier.
- start asserted in SCAN or RESULT is ignored and not queued.
- result_ack outside RESULT is ignored.

## Timing
- Reset: rst=1 at a rising edge forces IDLE from any state, including mid-SCAN and RESULT, and aborts the operation.
  - Reset values: busy=0, result_valid=0, class_idx=0, class_score=0, margin=0.
  - Internal k, best, second and the score register are cleared.
- rst has priority over start and result_ack in the same cycle.
- Let E0 be the edge sampling start=1 in IDLE.
  - busy=1 after E0.
  - SCAN processes k=1..CLASS_COUNT-1 on edges E1..E(CLASS_COUNT-1).
  - result_valid=1 after edge E(CLASS_COUNT-1); with defaults, 9 cycles after the start edge.
- Ack: result_ack=1 sampled in RESULT at edge Ea drops result_valid and busy after Ea. A new start is accepted no earlier than edge Ea+1.
- Throughput: one classification per CLASS_COUNT+1 cycles minimum, with ack held high.
- No combinational path from any input to any output.

## Test plan
- Distinct scores {10,20,30,250,40,50,60,70,80,90}, start pulse, ack after 3 cycles -> result_valid rises 9 cycles after start, class_idx=3, class_score=250, margin=160; outputs stable for 3 cycles; result_valid=0 the cycle after ack.
- Tie: scores all 0 except class 2=class 7=200 -> class_idx=2, class_score=200, margin=0.
- All scores 0 -> class_idx=0, class_score=0, margin=0; max at last class {0,...,0,255} -> class_idx=9, margin=255.
- Change `scores` and pulse start during SCAN and during RESULT -> result reflects the originally latched scores; no second run starts; busy stays 1 until ack.
- Assert rst at the 5th SCAN cycle -> next cycle busy=0, result_valid=0, all outputs 0; a following start completes normally with correct results.
- Back-to-back: ack held high, start reasserted the cycle after returning to IDLE with new scores -> second result_valid rises 9 cycles after that start with the new argmax.
